// File: rtl/pkt_gen_pkg.sv
// pkt_gen_pkg: shared widths, FSM states, packet layout and LFSR step for the packet generator
package pkt_gen_pkg;
  localparam int SEQ_W = 4;
  localparam int DATA_W = 8;
  localparam int PKT_W = 13;
  typedef enum logic {S_IDLE, S_SEND} state_t;
  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [DATA_W-1:0] payload;
    logic parity;
  } pkt_t;
  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction
endpackage

// File: rtl/pkt_gen_if.sv
// pkt_gen_if: request (src_valid/src_ready) and packet (dd_valid/dd_ready/packet) handshakes; master=environment, slave=generator
interface pkt_gen_if;
  import pkt_gen_pkg::*;
  logic src_valid;
  logic src_ready;
  logic dd_valid;
  logic dd_ready;
  logic [PKT_W-1:0] packet;
  modport master(output src_valid, dd_ready, input src_ready, dd_valid, packet);
  modport slave(input src_valid, dd_ready, output src_ready, dd_valid, packet);
endinterface

// File: rtl/pkt_lfsr8.sv
// pkt_lfsr8: 8-bit maximal LFSR (clk, rst async, advance steps once, value current state; zero SEED forced to 1)
module pkt_lfsr8 import pkt_gen_pkg::*; #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  output logic [7:0] value
);
  localparam logic [7:0] INIT = (SEED == 8'h00) ? 8'h01 : SEED;
  always_ff @(posedge clk or posedge rst)
    if (rst) value <= INIT;
    else if (advance) value <= lfsr_next(value);
endmodule

// File: rtl/pkt_gen_top.sv
// pkt_gen_top: one-in-flight packet generator (clk, rst async high, bus slave: src_valid/dd_ready in, src_ready/dd_valid/packet out)
module pkt_gen_top import pkt_gen_pkg::*; #(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic      clk,
  input logic      rst,
  pkt_gen_if.slave bus
);
  state_t state, state_next;
  logic [SEQ_W-1:0] seq;
  logic [DATA_W-1:0] lfsr;
  pkt_t pkt;
  logic accept, xfer;
  assign accept = (state == S_IDLE) && bus.src_valid;
  assign xfer = (state == S_SEND) && bus.dd_ready;
  pkt_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk(clk),
    .rst(rst),
    .advance(xfer),
    .value(lfsr)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_next;
  always_comb state_next = accept ? S_SEND : xfer ? S_IDLE : state;
  always_comb begin
    bus.src_ready = (state == S_IDLE);
    bus.dd_valid = (state == S_SEND);
    bus.packet = pkt;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      seq <= '0;
      pkt <= '0;
    end else begin
      if (accept) pkt <= '{seq: seq, payload: lfsr, parity: ^{seq, lfsr}};
      if (xfer) seq <= seq + 1'b1;
    end
endmodule

// File: tb/tb_pkt_gen_top.sv
// tb_pkt_gen_top: randomized scoreboard bench for pkt_gen_top against a transaction-level model
module tb_pkt_gen_top;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  int m_seq = 0;
  logic [7:0] m_lfsr = 8'hA5;
  bit m_busy = 0;
  logic [12:0] exp_q[$];
  int dut_xfers = 0;
  int n_pkt = 0;
  bit prev_v = 0;
  logic [12:0] hold = '0;
  pkt_gen_if bus();
  pkt_gen_top #(.LFSR_SEED(8'hA5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] ref_step(input logic [7:0] v);
    return {v[6:0], 1'($countones(v & 8'hB8) % 2)};
  endfunction
  function automatic logic [12:0] ref_pkt(input int s, input logic [7:0] d);
    logic [11:0] body;
    body = {4'(s), d};
    return {body, 1'($countones(body) % 2)};
  endfunction
  task automatic step(input logic sv, input logic dr);
    bus.src_valid = sv;
    bus.dd_ready = dr;
    @(posedge clk);
    if (!rst) begin
      if (!m_busy && sv) begin
        exp_q.push_back(ref_pkt(m_seq, m_lfsr));
        m_busy = 1;
      end else if (m_busy && dr) begin
        m_seq = (m_seq + 1) % 16;
        m_lfsr = ref_step(m_lfsr);
        m_busy = 0;
      end
    end
    #1;
  endtask
  task automatic model_reset();
    m_seq = 0;
    m_lfsr = 8'hA5;
    m_busy = 0;
    exp_q.delete();
  endtask
  always @(negedge clk) begin
    if (rst) begin
      chk("dd_valid_in_reset", 32'(bus.dd_valid), 0);
      prev_v = 0;
      n_pkt = 0;
    end else begin
      chk("dd_valid", 32'(bus.dd_valid), 32'(m_busy));
      chk("src_ready", 32'(bus.src_ready), 32'(!m_busy));
      if (bus.dd_valid) begin
        if (!prev_v) begin
          if (exp_q.size() == 0) chk("unexpected_packet", 32'(bus.packet), 32'h1_0000);
          else chk("packet", 32'(bus.packet), 32'(exp_q.pop_front()));
          if (n_pkt == 0) chk("first_packet", 32'(bus.packet), 32'h014A);
          if (n_pkt == 1) chk("second_packet", 32'(bus.packet), 32'h0294);
          if (n_pkt == 2) chk("third_packet", 32'(bus.packet), 32'h052B);
          n_pkt++;
          hold = bus.packet;
        end else chk("packet_stable", 32'(bus.packet), 32'(hold));
        chk("packet_xor", 32'(^bus.packet), 0);
        if (bus.dd_ready) dut_xfers++;
      end
      prev_v = bus.dd_valid;
    end
  end
  initial begin
    int x0, n;
    bus.src_valid = 1'b0;
    bus.dd_ready = 1'b0;
    rst = 1'b1;
    #7;
    chk("reset_dd_valid", 32'(bus.dd_valid), 0);
    chk("reset_src_ready", 32'(bus.src_ready), 1);
    chk("reset_packet", 32'(bus.packet), 0);
    rst = 1'b0;
    repeat (6) step(1, 1);
    n = 0;
    do begin step(1, 0); n++; end while (!m_busy && n < 10);
    chk("bp_reached_send", 32'(m_busy), 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0);
      chk("bp_dd_valid", 32'(bus.dd_valid), 1);
      chk("bp_src_ready", 32'(bus.src_ready), 0);
    end
    step(0, 1);
    chk("bp_release_src_ready", 32'(bus.src_ready), 1);
    x0 = dut_xfers;
    repeat (200) step(1, 1);
    chk("throughput_100", 32'(dut_xfers - x0), 100);
    repeat (300) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    repeat (4) step(0, 1);
    for (int i = 0; i < 20; i++) step(0, 1'(i % 2));
    repeat (4) step(1, 1);
    n = 0;
    do begin step(1, 0); n++; end while (!m_busy && n < 10);
    chk("rst_test_in_send", 32'(m_busy), 1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_mid_send_dd_valid", 32'(bus.dd_valid), 0);
    chk("rst_mid_send_src_ready", 32'(bus.src_ready), 1);
    step(0, 0);
    step(0, 0);
    rst = 1'b0;
    x0 = n_pkt;
    repeat (6) step(1, 1);
    chk("post_reset_packets", 32'(n_pkt - x0), 3);
    repeat (2) step(0, 0);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
